// File: rtl/ipa_exec_ctrl.sv
// Instruction sequencer for MRR/LDC/LDD/STD: owns the register file and runs each
// instruction as a multi-cycle FSM, holding LDD/STD memory requests until mem_ack.
module ipa_exec_ctrl #(
  parameter int DATA_W  = 20,
  parameter int NREGS   = 16,
  parameter int INSTR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [INSTR_W-1:0]       instr,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     done,
  output logic                     err,
  input  logic [$clog2(NREGS)-1:0] dbg_idx,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int IDX_W = $clog2(NREGS);

  localparam logic [3:0] OP_MRR = 4'h1;
  localparam logic [3:0] OP_LDC = 4'h2;
  localparam logic [3:0] OP_LDD = 4'h3;
  localparam logic [3:0] OP_STD = 4'h4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [INSTR_W-1:0] instr_p0;
  logic [DATA_W-1:0]  regs [NREGS];

  logic [3:0]        op;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  ro_idx;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] ro_val;
  logic              is_mrr, is_ldc, is_ldd, is_std, is_mem, is_legal;

  logic              accept;
  logic              issue_mem;
  logic              retire;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign op       = instr_p0[INSTR_W-1 -: 4];
  assign rd_idx   = instr_p0[24 +: IDX_W];
  assign ro_idx   = instr_p0[20 +: IDX_W];
  assign imm      = instr_p0[DATA_W-1:0];
  assign rd_val   = regs[rd_idx];
  assign ro_val   = regs[ro_idx];
  assign is_mrr   = (op == OP_MRR);
  assign is_ldc   = (op == OP_LDC);
  assign is_ldd   = (op == OP_LDD);
  assign is_std   = (op == OP_STD);
  assign is_mem   = is_ldd | is_std;
  assign is_legal = is_mrr | is_ldc | is_mem;

  assign dbg_data = regs[dbg_idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (instr_valid) state_nxt = EXEC;
      EXEC:     state_nxt = is_mem ? MEM_WAIT : IDLE;
      MEM_WAIT: if (mem_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // mem_we is only ever set for STD, so a read completing in MEM_WAIT is an LDD
  always_comb begin
    instr_ready = (state == IDLE);
    accept      = instr_ready && instr_valid;
    issue_mem   = (state == EXEC) && is_mem;
    retire      = ((state == EXEC) && !is_mem) || ((state == MEM_WAIT) && mem_ack);
    wr_en       = 1'b0;
    wr_data     = '0;
    if (state == EXEC && is_mrr) begin
      wr_en   = 1'b1;
      wr_data = ro_val;
    end else if (state == EXEC && is_ldc) begin
      wr_en   = 1'b1;
      wr_data = imm;
    end else if (state == MEM_WAIT && mem_ack && !mem_we) begin
      wr_en   = 1'b1;
      wr_data = mem_rdata;
    end
  end

  // p0: instruction latch
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       instr_p0 <= '0;
    else if (accept) instr_p0 <= instr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_idx] <= wr_data;
    end
  end

  // p1: memory request and retire pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (issue_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= is_std;
        mem_addr  <= is_std ? rd_val : ro_val;
        mem_wdata <= is_std ? ro_val : '0;
      end else if (state == MEM_WAIT && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      done <= retire;
      err  <= retire && (state == EXEC) && !is_legal;
    end
  end

endmodule

// File: tb/tb_ipa_exec_ctrl.sv
// Bench for ipa_exec_ctrl: directed instruction sequences, with a monitor that
// matches retire pulses and memory requests against queued expectations.
module tb_ipa_exec_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        mem_req;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [19:0] mem_wdata;
  logic        mem_ack;
  logic [19:0] mem_rdata;
  logic        done;
  logic        err;
  logic [3:0]  dbg_idx;
  logic [19:0] dbg_data;

  ipa_exec_ctrl #(.DATA_W(20), .NREGS(16), .INSTR_W(32)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done),
    .err(err), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [19:0] addr;
    logic [19:0] wdata;
  } memx_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    exp_err_q[$];
  memx_t mem_q[$];
  int    done_cyc[$];
  int    acc_cyc[$];
  bit    mon_e;
  memx_t mon_m;
  logic  req_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one entry per retire pulse and per memory request
  always @(posedge clock) begin
    #1;
    if (done) begin
      done_cyc.push_back(cyc);
      if (exp_err_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        mon_e = exp_err_q.pop_front();
        check("retire_err", {31'd0, err}, {31'd0, mon_e});
      end
    end else if (err) begin
      check("err_without_done", 1, 0);
    end
    if (mem_req && !req_prev) begin
      if (mem_q.size() == 0) check("unexpected_mem_req", 1, 0);
      else begin
        mon_m = mem_q.pop_front();
        check("mem_we", {31'd0, mem_we}, {31'd0, mon_m.we});
        check("mem_addr", {12'd0, mem_addr}, {12'd0, mon_m.addr});
        if (mon_m.we) check("mem_wdata", {12'd0, mem_wdata}, {12'd0, mon_m.wdata});
      end
    end
    req_prev = mem_req;
  end

  always @(negedge clock) begin
    if (!reset && instr_valid && instr_ready) acc_cyc.push_back(cyc);
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] ro, input logic [19:0] imm);
    return {op, rd, ro, imm};
  endfunction

  task automatic issue(input logic [31:0] w, input bit keep);
    @(negedge clock);
    instr = w;
    instr_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (instr_ready) begin
        @(posedge clock);
        #1;
        if (!keep) instr_valid = 1'b0;
        return;
      end
      @(negedge clock);
    end
    check("accept_timeout", 0, 1);
    instr_valid = 1'b0;
  endtask

  task automatic chk_reg(input logic [3:0] idx, input logic [19:0] exp);
    @(negedge clock);
    dbg_idx = idx;
    #1;
    check($sformatf("reg_R%0d", idx), {12'd0, dbg_data}, {12'd0, exp});
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      if (exp_err_q.size() == 0) return;
      @(negedge clock);
    end
    check("retire_timeout", exp_err_q.size(), 0);
  endtask

  task automatic wait_req();
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (mem_req) return;
    end
    check("mem_req_timeout", 0, 1);
  endtask

  // Holds off the ack for 'delay' cycles, checking the request stays put meanwhile
  task automatic mem_respond(input int delay, input logic [19:0] rdata, input logic [19:0] exp_addr);
    wait_req();
    for (int k = 0; k < delay; k++) begin
      check("mem_hold_req", {31'd0, mem_req}, 1);
      check("mem_hold_addr", {12'd0, mem_addr}, {12'd0, exp_addr});
      @(negedge clock);
    end
    mem_rdata = rdata;
    mem_ack = 1'b1;
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("mem_req_drop", {31'd0, mem_req}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int a0;
  int d0;

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    dbg_idx = '0;
    #12;
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_ready", {31'd0, instr_ready}, 1);
    @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of an outstanding LDD
    exp_err_q.push_back(1'b0);
    issue(mk(4'h2, 4'd5, 4'd0, 20'h11111), 1'b0);
    wait_idle();
    chk_reg(4'd5, 20'h11111);
    mem_q.push_back('{we: 1'b0, addr: 20'h11111, wdata: 20'h0});
    issue(mk(4'h3, 4'd6, 4'd5, 20'h0), 1'b0);
    wait_req();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_req", {31'd0, mem_req}, 0);
    check("rst_mid_mem_addr", {12'd0, mem_addr}, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_idx = i[3:0];
      #1;
      check("rst_mid_reg", {12'd0, dbg_data}, 0);
    end
    @(negedge clock);
    reset = 1'b0;
    mem_rdata = 20'h77777;
    mem_ack = 1'b1;
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clock);
    chk_reg(4'd6, 20'h0);
    check("late_ack_ready", {31'd0, instr_ready}, 1);

    // Back-to-back LDC then MRR
    exp_err_q.push_back(1'b0);
    exp_err_q.push_back(1'b0);
    issue(mk(4'h2, 4'd3, 4'd0, 20'hABCDE), 1'b1);
    issue(mk(4'h1, 4'd7, 4'd3, 20'h0), 1'b0);
    wait_idle();
    repeat (2) @(negedge clock);
    chk_reg(4'd7, 20'hABCDE);
    check("done_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 2);
    check("accept_spacing", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 2);

    // Self-copy is a harmless write
    exp_err_q.push_back(1'b0);
    issue(mk(4'h1, 4'd3, 4'd3, 20'h0), 1'b0);
    wait_idle();
    chk_reg(4'd3, 20'hABCDE);

    // STD [R1] <- R2
    exp_err_q.push_back(1'b0);
    exp_err_q.push_back(1'b0);
    issue(mk(4'h2, 4'd1, 4'd0, 20'h00100), 1'b0);
    issue(mk(4'h2, 4'd2, 4'd0, 20'h5A5A5), 1'b0);
    wait_idle();
    exp_err_q.push_back(1'b0);
    mem_q.push_back('{we: 1'b1, addr: 20'h00100, wdata: 20'h5A5A5});
    issue(mk(4'h4, 4'd1, 4'd2, 20'h0), 1'b0);
    mem_respond(1, 20'h0, 20'h00100);
    wait_idle();

    // LDD R4 <- [R1] with a slow ack
    d0 = done_cyc.size();
    exp_err_q.push_back(1'b0);
    mem_q.push_back('{we: 1'b0, addr: 20'h00100, wdata: 20'h0});
    issue(mk(4'h3, 4'd4, 4'd1, 20'h0), 1'b0);
    mem_respond(5, 20'h12345, 20'h00100);
    wait_idle();
    repeat (3) @(negedge clock);
    check("ldd_one_done", done_cyc.size() - d0, 1);
    chk_reg(4'd4, 20'h12345);

    // Illegal opcodes 0xF and 0x0
    exp_err_q.push_back(1'b1);
    exp_err_q.push_back(1'b1);
    issue(mk(4'hF, 4'd1, 4'd2, 20'hFFFFF), 1'b0);
    issue(mk(4'h0, 4'd2, 4'd1, 20'h00001), 1'b0);
    wait_idle();
    chk_reg(4'd1, 20'h00100);
    chk_reg(4'd2, 20'h5A5A5);
    chk_reg(4'd4, 20'h12345);

    // Three LDCs with instr_valid held high throughout
    a0 = acc_cyc.size();
    repeat (3) exp_err_q.push_back(1'b0);
    issue(mk(4'h2, 4'd8, 4'd0, 20'hAAAAA), 1'b1);
    issue(mk(4'h2, 4'd9, 4'd0, 20'h55555), 1'b1);
    issue(mk(4'h2, 4'd10, 4'd0, 20'hFFFFF), 1'b0);
    wait_idle();
    repeat (4) @(negedge clock);
    check("hold_valid_accepts", acc_cyc.size() - a0, 3);
    chk_reg(4'd8, 20'hAAAAA);
    chk_reg(4'd9, 20'h55555);
    chk_reg(4'd10, 20'hFFFFF);

    repeat (3) @(negedge clock);
    check("pending_retires", exp_err_q.size(), 0);
    check("pending_mem_reqs", mem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
